// File: rtl/spi_rx_buf_ctrl.sv
// -----------------------------------------------------------------------------
// spi_rx_buf_ctrl
//
// Hands the SPI receive buffer back and forth between its two users. The SPI
// slave interface fills the buffer, and a SysClk-domain consumer (host logic
// or a CPU bridge) reads it out. The block watches SPI slave select and the
// receive write strobe, and counts the bytes written during each SS-low
// transfer. When the transfer ends it passes the buffer to the consumer
// together with the length. While the consumer owns the buffer, SPI writes
// are gated off, and an SS-low transfer that starts anyway is flagged as an
// overrun.
//
// Ports
//   SysClk     in   system clock, all logic on its rising edge
//   Reset      in   synchronous, active-high reset
//   SpiSS      in   raw SPI slave select, active low, asynchronous
//   RcMemWE    in   receive write strobe from the SPI interface, asynchronous
//   RcWeGate   out  1 = SPI writes into the receive buffer are allowed
//   RxReady    out  buffer holds a complete transfer owned by the consumer
//   RxLen      out  byte count of the held transfer (AddrBits+1 bits)
//   RxAck      in   single-cycle pulse from the consumer, buffer released
//   RxOverrun  out  sticky, an SS-low transfer started while RxReady=1
//   RxErr      out  sticky, transfer aborted (saturation or timeout)
//   ClrFlags   in   pulse, clears RxOverrun and RxErr (a same-cycle set wins)
//   Status     out  {RxReady, RxOverrun, RxErr, busy, 2'b00, state[1:0]}
//
// Consumer handshake: RxReady is the valid side. It rises the cycle after a
// transfer completes and stays high, with RxLen stable, until the consumer
// pulses RxAck for one cycle. RxAck is ignored whenever RxReady is low.
//
// Optional build macro: SPI_RX_TIMEOUT_EN. When it is defined, an ACTIVE
// transfer that sees no write strobe for TimeoutCycles cycles is aborted with
// RxErr. When it is not defined, no timeout counter is built.
//
// Status[1:0] shows the FSM state for debug: IDLE=0, ACTIVE=1, HOLD=2,
// DRAIN=3.
// -----------------------------------------------------------------------------
module spi_rx_buf_ctrl #(
  parameter int AddrBits      = 12,
  parameter int SyncStages    = 2,
  parameter int TimeoutCycles = 65536
) (
  input  logic              SysClk,
  input  logic              Reset,
  input  logic              SpiSS,
  input  logic              RcMemWE,
  output logic              RcWeGate,
  output logic              RxReady,
  output logic [AddrBits:0] RxLen,
  input  logic              RxAck,
  output logic              RxOverrun,
  output logic              RxErr,
  input  logic              ClrFlags,
  output logic [7:0]        Status
);

  // Elaboration-time sanity checks on the parameters.
  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("spi_rx_buf_ctrl: SyncStages must be at least 2");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("spi_rx_buf_ctrl: TimeoutCycles must be at least 2");
  end

  localparam int CW = AddrBits + 1;
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {AddrBits{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detectors.
  // These flops have no reset, because the idle levels (SS=1, WE=0) flush
  // through them within the first few clocks. Each edge pulse is formed from
  // the final sync stage and a one-cycle-delayed copy of that stage. As a
  // result, the FSM reacts on the (SyncStages+1)th rising edge after a raw
  // input edge.
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0] ss_sync;
  logic [SyncStages-1:0] we_sync;
  logic                  ss_prev;
  logic                  we_prev;

  always_ff @(posedge SysClk) begin
    ss_sync <= {ss_sync[SyncStages-2:0], SpiSS};
    we_sync <= {we_sync[SyncStages-2:0], RcMemWE};
    ss_prev <= ss_sync[SyncStages-1];
    we_prev <= we_sync[SyncStages-1];
  end

  logic ss_fall;
  logic ss_rise;
  logic we_rise;

  assign ss_fall = ss_prev & ~ss_sync[SyncStages-1];
  assign ss_rise = ~ss_prev & ss_sync[SyncStages-1];
  assign we_rise = ~we_prev & we_sync[SyncStages-1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   byte_cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   cnt_count;
  logic [CW-1:0]   rx_len;
  logic [CW-1:0]   len_next;
  logic            overrun;
  logic            err;
  logic            ovr_set;
  logic            err_set;
  logic            tmo_hit;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

  logic [TW-1:0] tmo_cnt;

  // The counter only runs in ACTIVE, so it starts every transfer at zero.
  // Any write strobe restarts the inactivity window.
  always_ff @(posedge SysClk) begin
    if (Reset || state != ST_ACTIVE || we_rise) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state == ST_ACTIVE) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      rx_len    <= '0;
      overrun   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      byte_cnt  <= cnt_next;
      rx_len    <= len_next;
      // If a set event and ClrFlags arrive in the same cycle, the set wins.
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ClrFlags) begin
        overrun <= 1'b0;
      end
      if (err_set) begin
        err <= 1'b1;
      end else if (ClrFlags) begin
        err <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = byte_cnt;
    len_next   = rx_len;
    ovr_set    = 1'b0;
    err_set    = 1'b0;
    cnt_count  = we_rise ? (byte_cnt + CW'(1)) : byte_cnt;

    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_next = ST_ACTIVE;
          cnt_next   = '0;
        end
      end

      ST_ACTIVE: begin
        if (we_rise && byte_cnt == CNT_FULL) begin
          // Counter saturation: the byte does not fit. The counter holds.
          // If SS rises in this same cycle there is nothing left to drain.
          err_set    = 1'b1;
          state_next = ss_rise ? ST_IDLE : ST_DRAIN;
        end else begin
          // A byte and the end of the transfer in the same cycle: the
          // byte is counted first, then the end-of-transfer rule applies.
          cnt_next = cnt_count;
          if (ss_rise) begin
            if (cnt_count == '0) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_HOLD;
              len_next   = cnt_count;
            end
          end else if (tmo_hit && !we_rise) begin
            err_set    = 1'b1;
`ifdef SPI_RX_TIMEOUT_EN
            state_next = ss_sync[SyncStages-1] ? ST_IDLE : ST_DRAIN;
`else
            state_next = ST_DRAIN;
`endif
          end
        end
      end

      ST_HOLD: begin
        if (RxAck) begin
          // When a release and a new transfer arrive together, the release
          // wins. The new transfer is accepted and is not an overrun.
          if (ss_fall) begin
            state_next = ST_ACTIVE;
            cnt_next   = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (ss_fall) begin
          ovr_set = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (ss_rise) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RxReady   = (state == ST_HOLD);
  assign RcWeGate  = (state == ST_IDLE) || (state == ST_ACTIVE);
  assign RxLen     = rx_len;
  assign RxOverrun = overrun;
  assign RxErr     = err;
  assign Status    = {RxReady, overrun, err, (state == ST_ACTIVE), 2'b00, state};

endmodule
